// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS core: MDU opcode encodings, MDU FSM state
// encoding and the default datapath width.
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MFHI  = 3'd4,
      MDU_MFLO  = 3'd5,
      MDU_MTHI  = 3'd6,
      MDU_MTLO  = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      RUN  = 2'd2,
      FIX  = 2'd3
   } mdu_state_e;

   // Signed ops get absolute-value operands and a final sign correction.
   function automatic logic is_signed_op(mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// -----------------------------------------------------------------------------
// mdu_step
// Combinational single-iteration datapath of the iterative MDU.
//   Multiply : shift-add; if acc[0], add m into the upper half, then shift the
//              whole (XLEN+1)-bit-carry accumulator right by one.
//   Divide   : restoring; shift {rem,quo} left, trial-subtract m from the
//              remainder, keep the difference and set quotient bit if no borrow.
// Build option: MDU_DIV_EN adds the divide path and the is_div select.
// Ports:
//   is_div    in   1       select divide step (only with MDU_DIV_EN)
//   acc       in   2*XLEN  current accumulator ({HI part, LO part})
//   m         in   XLEN    multiplicand / divisor (absolute value)
//   acc_next  out  2*XLEN  accumulator after one iteration
// -----------------------------------------------------------------------------
module mdu_step
   import mips_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
`ifdef MDU_DIV_EN
   input  logic              is_div,
`endif
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   m,
   output logic [2*XLEN-1:0] acc_next
);

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;

   // Carry out of the add becomes the new MSB after the right shift.
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
   assign mul_next = {mul_sum, acc[XLEN-1:1]};

`ifdef MDU_DIV_EN
   logic [XLEN:0]     rem_sh;
   logic              rem_ge;
   logic [XLEN-1:0]   rem_diff;
   logic [2*XLEN-1:0] div_next;

   // Shifted remainder needs one extra bit; since rem < m it never exceeds 2m,
   // so the low XLEN bits of the modular difference are the exact remainder.
   assign rem_sh   = acc[2*XLEN-1:XLEN-1];
   assign rem_ge   = (rem_sh >= {1'b0, m});
   assign rem_diff = rem_sh[XLEN-1:0] - m;
   assign div_next = rem_ge ? {rem_diff, acc[XLEN-2:0], 1'b1}
                            : {acc[2*XLEN-2:0], 1'b0};

   assign acc_next = is_div ? div_next : mul_next;
`else
   assign acc_next = mul_next;
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
// Iterative multiply/divide controller beside EX. Owns HI/LO, runs MULT/MULTU
// (and DIV/DIVU with MDU_DIV_EN) one bit per cycle through mdu_step, serves
// MFHI/MFLO/MTHI/MTLO, and stalls ID while an iterative op is in flight.
// Build option: MDU_DIV_EN enables DIV/DIVU; without it they are no-ops.
// Ports:
//   clk      in   1     core clock, rising edge
//   rst      in   1     asynchronous active-high reset
//   issue    in   1     valid MDU instruction in ID
//   op       in   3     MDU opcode (mdu_op_e)
//   a, b     in   XLEN  rs / rt operands after forwarding
//   stall    out  1     issue not accepted (issue & busy), combinational
//   busy     out  1     FSM not IDLE
//   done     out  1     one-cycle pulse after an iterative op writes HI/LO
//   rd_data  out  XLEN  HI for accepted MFHI, LO for accepted MFLO, else 0
//   hi, lo   out  XLEN  architectural HI/LO
// -----------------------------------------------------------------------------
module mdu_ctrl
   import mips_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue,
   input  mdu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] rd_data,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int            CW   = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   mdu_state_e        state;
   mdu_op_e           op_q;
   logic [XLEN-1:0]   a_q, b_q, m_q;
   logic [2*XLEN-1:0] acc, acc_next, prod;
   logic [CW-1:0]     cnt;
   logic              neg_res;
   logic              accept, iter_op, sgn;
   logic [XLEN-1:0]   abs_a, abs_b, fix_hi, fix_lo;

   assign busy   = (state != IDLE);
   assign stall  = issue & busy;
   assign accept = issue & ~stall;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      iter_op = 1'b0;
      case (op)
         MDU_MULT, MDU_MULTU: iter_op = 1'b1;
`ifdef MDU_DIV_EN
         MDU_DIV, MDU_DIVU:   iter_op = 1'b1;
`endif
         default:             iter_op = 1'b0;
      endcase
   end

   always_comb begin
      rd_data = '0;
      if (accept && op == MDU_MFHI) rd_data = hi;
      else if (accept && op == MDU_MFLO) rd_data = lo;
   end

   assign sgn   = is_signed_op(op_q);
   assign abs_a = (sgn && a_q[XLEN-1]) ? -a_q : a_q;
   assign abs_b = (sgn && b_q[XLEN-1]) ? -b_q : b_q;

`ifdef MDU_DIV_EN
   logic is_div_q;
   logic neg_rem;
   assign is_div_q = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
`endif

   mdu_step #(.XLEN(XLEN)) u_step (
`ifdef MDU_DIV_EN
      .is_div   (is_div_q),
`endif
      .acc      (acc),
      .m        (m_q),
      .acc_next (acc_next)
   );

   // Sign correction and special cases applied in FIX.
   always_comb begin
      prod   = neg_res ? -acc : acc;
      fix_hi = prod[2*XLEN-1:XLEN];
      fix_lo = prod[XLEN-1:0];
`ifdef MDU_DIV_EN
      if (is_div_q) begin
         if (b_q == '0) begin
            // Divide by zero: quotient all-ones, remainder is the raw dividend.
            fix_hi = a_q;
            fix_lo = '1;
         end else begin
            // Overflow (MIN / -1) falls out naturally: -(2^(XLEN-1)) wraps to itself.
            fix_lo = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            fix_hi = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
         end
      end
`endif
   end

   // NOTE: all registers, including the operand and accumulator datapath, are
   // cleared on reset so an aborted op never leaves stale or X state behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         op_q    <= MDU_MULT;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
         acc     <= '0;
         cnt     <= '0;
         neg_res <= 1'b0;
`ifdef MDU_DIV_EN
         neg_rem <= 1'b0;
`endif
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge
         // values regardless of statement order.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (op == MDU_MTHI) hi <= a;
                  if (op == MDU_MTLO) lo <= a;
                  if (iter_op) begin
                     op_q  <= op;
                     a_q   <= a;
                     b_q   <= b;
                     state <= PREP;
                  end
               end
            end
            PREP: begin
               acc     <= {{XLEN{1'b0}}, abs_a};
               m_q     <= abs_b;
               neg_res <= sgn & (a_q[XLEN-1] ^ b_q[XLEN-1]);
`ifdef MDU_DIV_EN
               neg_rem <= sgn & a_q[XLEN-1];
`endif
               cnt     <= '0;
               state   <= RUN;
            end
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
// Self-checking bench for mdu_ctrl. Expected {HI,LO} for each iterative op is
// queued when issued and compared when DONE pulses. Divide cases follow the
// MDU_DIV_EN build option.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;
   import mips_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            issue;
   mdu_op_e         op;
   logic [XLEN-1:0] a, b;
   logic            stall, busy, done;
   logic [XLEN-1:0] rd_data, hi, lo;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb_q[$];
   logic [63:0] mon_exp;

   mdu_ctrl #(.XLEN(XLEN)) dut (
      .clk     (clk),
      .rst     (rst),
      .issue   (issue),
      .op      (op),
      .a       (a),
      .b       (b),
      .stall   (stall),
      .busy    (busy),
      .done    (done),
      .rd_data (rd_data),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model for {HI,LO}.
   function automatic logic [63:0] model(input mdu_op_e o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sp;
      logic signed [31:0] sx, sy;
      sx = x;
      sy = y;
      case (o)
         MDU_MULT: begin
            sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            return sp;
         end
         MDU_MULTU: return {32'd0, x} * {32'd0, y};
         MDU_DIVU: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
         MDU_DIV: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {sx % sy, sx / sy};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Scoreboard: each DONE pops one expected result.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("done_spurious", 64'd1, 64'd0);
         end else begin
            mon_exp = sb_q.pop_front();
            check("hilo", {hi, lo}, mon_exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic run_iter(input string tag, input mdu_op_e o, input logic [31:0] x,
                           input logic [31:0] y, input logic [63:0] exp);
      int cyc = 0;
      wait_idle();
      @(negedge clk);
      issue = 1'b1; op = o; a = x; b = y;
      #1 check({tag, "_stall"}, 64'(stall), 64'd0);
      sb_q.push_back(exp);
      @(negedge clk);
      issue = 1'b0;
      while (busy === 1'b1 && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, 64'(cyc), 64'd34);
      check({tag, "_done_hi"}, 64'(done), 64'd1);
      @(negedge clk);
      check({tag, "_done_lo"}, 64'(done), 64'd0);
   endtask

`ifndef MDU_DIV_EN
   task automatic noop_div(input string tag, input mdu_op_e o);
      logic [63:0] prev;
      wait_idle();
      prev = {hi, lo};
      @(negedge clk);
      issue = 1'b1; op = o; a = 32'd100; b = 32'd7;
      @(negedge clk);
      issue = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'd0);
      @(negedge clk);
      check({tag, "_hilo"}, {hi, lo}, prev);
   endtask
`endif

   initial begin
      int cyc;
      mdu_op_e ro;
      logic [31:0] rx, ry;

      rst = 1'b1; issue = 1'b0; op = MDU_MULT; a = '0; b = '0;
      repeat (2) @(negedge clk);
      issue = 1'b1; op = MDU_MFHI;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      issue = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Moves to/from HI/LO.
      @(negedge clk);
      issue = 1'b1; op = MDU_MTHI; a = 32'hCAFE_0001;
      @(negedge clk);
      op = MDU_MTLO; a = 32'h0BEE_F002;
      #1 check("mthi", 64'(hi), 64'h0000_0000_CAFE_0001);
      @(negedge clk);
      op = MDU_MFHI;
      #1;
      check("mtlo", 64'(lo), 64'h0000_0000_0BEE_F002);
      check("mfhi", 64'(rd_data), 64'h0000_0000_CAFE_0001);
      op = MDU_MFLO;
      #1 check("mflo", 64'(rd_data), 64'h0000_0000_0BEE_F002);
      issue = 1'b0;
      #1 check("rd_idle", 64'(rd_data), 64'd0);

      // Multiplies.
      run_iter("mult_neg3x7", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
      run_iter("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_iter("mult_min", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

`ifdef MDU_DIV_EN
      run_iter("divu_100_7", MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
      run_iter("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_iter("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
      run_iter("div_by0", MDU_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
      run_iter("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
      run_iter("divu_by0", MDU_DIVU, 32'h8000_0000, 32'd0, {32'h8000_0000, 32'hFFFF_FFFF});
`else
      noop_div("div_noop", MDU_DIV);
      noop_div("divu_noop", MDU_DIVU);
`endif

      // Randomised ops against the model.
      for (int i = 0; i < 6; i++) begin
`ifdef MDU_DIV_EN
         ro = mdu_op_e'($urandom_range(0, 3));
`else
         ro = mdu_op_e'($urandom_range(0, 1));
`endif
         rx = $urandom;
         ry = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
         run_iter("rand", ro, rx, ry, model(ro, rx, ry));
      end

      // MULT followed by a dependent MFLO held by STALL.
      wait_idle();
      @(negedge clk);
      issue = 1'b1; op = MDU_MULT; a = 32'd6; b = 32'd7;
      sb_q.push_back(64'd42);
      @(negedge clk);
      op = MDU_MFLO;
      #1;
      check("mflo_stalled_rd", 64'(rd_data), 64'd0);
      cyc = 0;
      while (stall === 1'b1 && cyc < 100) begin
         cyc++;
         @(negedge clk);
         #1;
      end
      check("mflo_stall_cycles", 64'(cyc), 64'd34);
      check("mflo_after_mult", 64'(rd_data), 64'd42);
      @(negedge clk);
      issue = 1'b0;

      // Reset in the middle of RUN (iteration 10).
      @(negedge clk);
      issue = 1'b1; op = MDU_MTHI; a = 32'h55AA;
      @(negedge clk);
      op = MDU_MULT; a = 32'd3; b = 32'd5;
      @(negedge clk);
      issue = 1'b0;
      repeat (11) @(negedge clk);
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hilo", {hi, lo}, 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_hilo_hold", {hi, lo}, 64'd0);
      issue = 1'b1; op = MDU_MTHI; a = 32'h1234;
      @(negedge clk);
      op = MDU_MFHI;
      #1 check("mfhi_after_rst", 64'(rd_data), 64'h1234);
      @(negedge clk);
      issue = 1'b0;

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide controller for the pipelined MIPS CPU. It sits beside the EX stage, owns the HI/LO registers, and sequences a one-bit-per-cycle shift-add multiplier and restoring divider for MULT, MULTU, DIV and DIVU. It also serves MFHI, MFLO, MTHI and MTLO. While an operation is in flight it drives a stall back to the hazard logic, so dependent HI/LO accesses and new MDU ops hold in ID.

## Interface
Parameters:
- XLEN, 32, operand and HI/LO width; iteration count equals XLEN.

Ports:
- CLK  in  1  core clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ISSUE  in  1  a valid MDU instruction is presented in ID this cycle.
- OP  in  3  MDU opcode from the shared package.
- A  in  XLEN  rs operand, after forwarding.
- B  in  XLEN  rt operand, after forwarding.
- STALL  out  1  combinational; high = ISSUE not accepted, so hold ID and bubble EX.
- BUSY  out  1  an operation is in flight (state is not IDLE).
- DONE  out  1  one-cycle pulse after HI/LO are written by an iterative op.
- RD_DATA  out  XLEN  combinational HI (MFHI) or LO (MFLO); otherwise 0.
- HI  out  XLEN  architectural HI.
- LO  out  XLEN  architectural LO.

## Operation
- Reset values: state=IDLE, HI=0, LO=0, BUSY=0, DONE=0, counter=0. STALL and RD_DATA evaluate to 0.
- STALL = ISSUE & BUSY, for every MDU opcode. No other stall source.
- Accept = ISSUE & ~STALL.
- MTHI/MTLO accepted: HI (or LO) <= A at the next edge. No BUSY.
- MFHI/MFLO accepted: RD_DATA = HI (or LO) in the same cycle. No state change.
- Iterative op accepted: latch the opcode, A and B, then go to PREP.
- FSM:
  - IDLE -> PREP on an accepted iterative op.
  - PREP: take absolute values for the signed ops and record the sign flags. Go to RUN with counter=0.
  - RUN: one iteration per cycle. Multiply is shift-add into a 2·XLEN accumulator. Divide is restoring: shift the remainder, trial-subtract, set the quotient bit. When counter=XLEN-1, go to FIX.
  - FIX: apply sign correction and write HI/LO. Go to IDLE and set DONE for the following cycle.
- Arithmetic rules:
  - Multiply: {HI,LO} = full 2·XLEN product. Signed result is negated when sign(A)≠sign(B).
  - Divide: LO=quotient, HI=remainder. Quotient sign = sA^sB. Remainder takes the sign of A.
  - Divide by zero (all divides): LO=all-ones, HI=A.
  - Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
- RST mid-operation: aborts immediately, FSM to IDLE, HI/LO cleared. A partial result is never written.
- Opcodes outside the defined set, when accepted, are ignored.

## Timing
- Iterative op accepted at edge t0 (counting from cycle 0).
- BUSY is high from after t0 until after t34: PREP 1 cycle, RUN 32 cycles, FIX 1 cycle. BUSY is high for 34 cycles.
- HI/LO are updated at edge t34. DONE is high for the one cycle after t34.
- An instruction issued during BUSY, including the FIX cycle, is accepted in the first cycle BUSY=0. A back-to-back MFLO therefore sees the new LO.
- MTHI/MTLO latency is 1 edge. MFHI/MFLO latency is 0 (combinational).

## Configuration
- MDU_DIV_EN defined: DIV/DIVU are supported as described.
- MDU_DIV_EN undefined:
  - Divider datapath and divide sign logic are removed.
  - DIV/DIVU are accepted as no-ops: no BUSY, HI/LO unchanged.
  - MULT/MULTU timing is identical to the defined case.

## Structure
- Shared package mips_pkg holds:
  - OP encodings: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MFHI=4, MDU_MFLO=5, MDU_MTHI=6, MDU_MTLO=7.
  - FSM state encoding: IDLE, PREP, RUN, FIX.
  - XLEN default.
- Sub-module mdu_step: combinational one-iteration datapath (add-or-pass for multiply, trial subtract for divide). mdu_ctrl holds the FSM, counter, operand/accumulator registers and HI/LO.

## Test plan
- MULT A=0xFFFFFFFD (-3), B=7 -> BUSY high for 34 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; DONE pulses exactly one cycle.
- DIVU A=100, B=7 -> LO=14, HI=2.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=5, B=0 -> LO=0xFFFFFFFF, HI=5. Then DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT A=6, B=7, then MFLO presented the next cycle -> STALL high for 34 cycles; MFLO accepted when BUSY falls with RD_DATA=42.
- RST asserted at RUN iteration 10 -> BUSY=0 and HI=LO=0 immediately, no DONE. After release, MTHI A=0x1234 then MFHI -> RD_DATA=0x1234.
